// File: rtl/bam8_shared_mul_arbiter.sv
// Round-robin front end sharing one 8x8 broken-array approximate multiplier among N_REQ lanes.
// Stage 1 holds the granted operands and ID; stage 2 holds the registered product.
module bam8_shared_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int BAM_H = 1,
  parameter int BAM_V = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_prod,
  output logic                 busy
);

  logic [7:0] op_a [N_REQ];
  logic [7:0] op_b [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[8*gi +: 8];
      assign op_b[gi] = req_b[8*gi +: 8];
    end
  endgenerate

  // Kept partial products: row j >= BAM_H and weight i+j >= BAM_V.
  function automatic logic [15:0] bam(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) begin
        if ((i + j >= BAM_V) && (j >= BAM_H)) begin
          acc = acc + ({15'd0, a[i] & b[j]} << (i + j));
        end
      end
    end
    return acc;
  endfunction

  logic            s1_vld_q, s1_vld_d;
  logic [7:0]      s1_a_q, s1_a_d;
  logic [7:0]      s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s2_vld_q, s2_vld_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_prod_q, rsp_prod_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            s2_adv, s1_adv;
  logic            grant_found;
  logic [ID_W-1:0] grant_id;

  assign s2_adv = !s2_vld_q || rsp_ready;
  assign s1_adv = !s1_vld_q || s2_adv;

  // No grant while reset is asserted, so no requester believes it was accepted.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    grant_found = 1'b0;
    grant_id    = '0;
    req_ready   = '0;
    idx         = 0;
    idx_w       = '0;
    if (rst_n && en && s1_adv) begin
      for (int off = 1; off <= N_REQ; off++) begin
        idx = int'(rr_ptr_q) + off;
        if (idx >= N_REQ) idx = idx - N_REQ;
        idx_w = ID_W'(idx);
        if (!grant_found && req_valid[idx_w]) begin
          grant_found = 1'b1;
          grant_id    = idx_w;
        end
      end
    end
    if (grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_vld_d   = s2_vld_q;
    rsp_id_d   = rsp_id_q;
    rsp_prod_d = rsp_prod_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_found) begin
      s1_vld_d = 1'b1;
      s1_a_d   = op_a[grant_id];
      s1_b_d   = op_b[grant_id];
      s1_id_d  = grant_id;
      rr_ptr_d = grant_id;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end
    if (s2_adv) begin
      s2_vld_d   = s1_vld_q;
      rsp_prod_d = bam(s1_a_q, s1_b_q);
      rsp_id_d   = s1_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_vld_q   <= 1'b0;
      rsp_id_q   <= '0;
      rsp_prod_q <= '0;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_vld_q   <= s2_vld_d;
      rsp_id_q   <= rsp_id_d;
      rsp_prod_q <= rsp_prod_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rsp_valid = s2_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign busy      = s1_vld_q || s2_vld_q;

endmodule
